// File: rtl/alu_pkg.sv
// Shared ALU operation codes for the ALU control decoder and the execute unit.
// Keeping the codes here gives them a single definition across the datapath.
package alu_pkg;

    typedef enum logic [3:0] {
        ALU_AND      = 4'b0000,
        ALU_OR       = 4'b0001,
        ALU_ADD      = 4'b0010,
        ALU_SUB      = 4'b0110,
        ALU_PASSB_Z  = 4'b0111,
        ALU_PASSB_NZ = 4'b1111
    } alu_op_t;

    localparam int ALU_OP_W = 4;

    function automatic logic is_legal_op(input logic [ALU_OP_W-1:0] code);
        case (code)
            ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_PASSB_Z, ALU_PASSB_NZ:
                is_legal_op = 1'b1;
            default:
                is_legal_op = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational ALU: result, branch zero flag and illegal-code flag.
// zero=1 always means "branch condition true" for CBZ/CBNZ.
module alu_core
    import alu_pkg::*;
#(
    parameter int N = 64
) (
    input  logic [ALU_OP_W-1:0] op,
    input  logic [N-1:0]        a,
    input  logic [N-1:0]        b,
    output logic [N-1:0]        result,
    output logic                zero,
    output logic                illegal
);

    logic legal;

    always_comb begin
        legal = is_legal_op(op);
    end

    always_comb begin
        result = '0;
        case (op)
            ALU_AND:      result = a & b;
            ALU_OR:       result = a | b;
            ALU_ADD:      result = a + b;
            ALU_SUB:      result = a - b;
            ALU_PASSB_Z:  result = b;
            ALU_PASSB_NZ: result = b;
            default:      result = '0;
        endcase
    end

    // Branch codes derive zero from b directly; illegal tokens report zero=1.
    always_comb begin
        zero    = 1'b1;
        illegal = 1'b0;
        if (!legal) begin
            zero    = 1'b1;
            illegal = 1'b1;
        end else if (op == ALU_PASSB_Z) begin
            zero = (b == '0);
        end else if (op == ALU_PASSB_NZ) begin
            zero = (b != '0);
        end else begin
            zero = (result == '0);
        end
    end

endmodule

// File: rtl/alu_exec_pipe.sv
// Two-stage handshaked EX unit: S1 holds the operation, S2 holds the result.
// Absorbs back-pressure from MEM with strict FIFO order and max two tokens.
module alu_exec_pipe
    import alu_pkg::*;
#(
    parameter int N = 64
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [ALU_OP_W-1:0] alucontrol,
    input  logic [N-1:0]        a,
    input  logic [N-1:0]        b,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [N-1:0]        result,
    output logic                zero,
    output logic                illegal
);

    // Handshake: a transfer happens on a rising edge where valid && ready.
    // Producers hold valid and data steady until accepted; each stage is
    // ready when empty or when its occupant leaves on the same edge, and
    // no ready signal depends on the matching valid.

    logic                s1_valid;
    logic [ALU_OP_W-1:0] s1_op;
    logic [N-1:0]        s1_a;
    logic [N-1:0]        s1_b;

    logic                s2_valid;
    logic [N-1:0]        s2_result;
    logic                s2_zero;
    logic                s2_illegal;

    logic                s1_ready;
    logic                s2_ready;

    logic [N-1:0]        core_result;
    logic                core_zero;
    logic                core_illegal;

    always_comb begin
        s2_ready = !s2_valid || out_ready;
        s1_ready = !s1_valid || s2_ready;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            s1_valid <= 1'b0;
            s1_op    <= '0;
            s1_a     <= '0;
            s1_b     <= '0;
        end else if (s1_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_op <= alucontrol;
                s1_a  <= a;
                s1_b  <= b;
            end
        end
    end

    alu_core #(
        .N(N)
    ) u_alu_core (
        .op      (s1_op),
        .a       (s1_a),
        .b       (s1_b),
        .result  (core_result),
        .zero    (core_zero),
        .illegal (core_illegal)
    );

    // S2 only reloads when empty or draining, so a stalled output stays put.
    always_ff @(posedge clk) begin
        if (!reset) begin
            s2_valid   <= 1'b0;
            s2_result  <= '0;
            s2_zero    <= 1'b0;
            s2_illegal <= 1'b0;
        end else if (s2_ready) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_result  <= core_result;
                s2_zero    <= core_zero;
                s2_illegal <= core_illegal;
            end
        end
    end

    always_comb begin
        in_ready  = s1_ready;
        out_valid = s2_valid;
        result    = s2_result;
        zero      = s2_zero;
        illegal   = s2_illegal;
    end

endmodule

// File: tb/tb_alu_exec_pipe.sv
// Directed bench for alu_exec_pipe: reset, streaming, branch codes,
// wrap-around, illegal codes, back-pressure and reset with tokens in flight.
module tb_alu_exec_pipe;

    localparam int N = 64;

    logic         clk;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [3:0]   alucontrol;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] result;
    logic         zero;
    logic         illegal;

    int n_pass;
    int n_total;

    alu_exec_pipe #(
        .N(N)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .alucontrol (alucontrol),
        .a          (a),
        .b          (b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .result     (result),
        .zero       (zero),
        .illegal    (illegal)
    );

    // clock / reset block
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] op, input logic [N-1:0] va, input logic [N-1:0] vb);
        in_valid   = 1'b1;
        alucontrol = op;
        a          = va;
        b          = vb;
    endtask

    task automatic idle();
        in_valid   = 1'b0;
        alucontrol = 4'b0000;
        a          = '0;
        b          = '0;
    endtask

    task automatic check(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic check_out(input string tag, input logic [N-1:0] exp_res,
                             input logic exp_zero, input logic exp_ill);
        check({tag, ".valid"}, N'(out_valid), N'(1'b1));
        check({tag, ".result"}, result, exp_res);
        check({tag, ".zero"}, N'(zero), N'(exp_zero));
        check({tag, ".illegal"}, N'(illegal), N'(exp_ill));
    endtask

    initial begin
        n_pass    = 0;
        n_total   = 0;
        reset     = 1'b0;
        out_ready = 1'b1;
        drive(4'b0010, 64'd5, 64'd7);

        // 1. reset held low three cycles with in_valid asserted
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst.out_valid", N'(out_valid), N'(1'b0));
            check("rst.result", result, '0);
            check("rst.zero", N'(zero), N'(1'b0));
            check("rst.illegal", N'(illegal), N'(1'b0));
        end
        reset = 1'b1;
        idle();
        check("rst.in_ready", N'(in_ready), N'(1'b1));
        tick();

        // 2. back-to-back stream
        drive(4'b0010, 64'd5, 64'd7);
        tick();
        check("str.lat_valid", N'(out_valid), N'(1'b0));
        drive(4'b0110, 64'd9, 64'd9);
        tick();
        check_out("str.add", 64'd12, 1'b0, 1'b0);
        drive(4'b0000, 64'hF0, 64'h0F);
        tick();
        check_out("str.sub", 64'd0, 1'b1, 1'b0);
        drive(4'b0001, 64'hF0, 64'h0F);
        tick();
        check_out("str.and", 64'd0, 1'b1, 1'b0);
        idle();
        tick();
        check_out("str.or", 64'hFF, 1'b0, 1'b0);
        tick();
        check("str.drain", N'(out_valid), N'(1'b0));

        // 3. branch codes
        drive(4'b0111, 64'd5, 64'd0);
        tick();
        drive(4'b1111, 64'd5, 64'd0);
        tick();
        check_out("br.cbz_b0", 64'd0, 1'b1, 1'b0);
        drive(4'b1111, 64'd0, 64'd3);
        tick();
        check_out("br.cbnz_b0", 64'd0, 1'b0, 1'b0);
        idle();
        tick();
        check_out("br.cbnz_b3", 64'd3, 1'b1, 1'b0);

        // 4. wrap-around and illegal code
        drive(4'b0110, 64'd0, 64'd1);
        tick();
        drive(4'b0010, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
        tick();
        check_out("wrap.sub", 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0);
        drive(4'b0011, 64'd5, 64'd7);
        tick();
        check_out("wrap.add", 64'd0, 1'b1, 1'b0);
        idle();
        tick();
        check_out("ill.0011", 64'd0, 1'b1, 1'b1);
        tick();
        check("ill.drain", N'(out_valid), N'(1'b0));

        // 5. back-pressure
        out_ready = 1'b0;
        drive(4'b0010, 64'd1, 64'd1);
        tick();
        check("bp.in_ready1", N'(in_ready), N'(1'b1));
        drive(4'b0010, 64'd2, 64'd2);
        tick();
        check_out("bp.hold0", 64'd2, 1'b0, 1'b0);
        check("bp.full_ready", N'(in_ready), N'(1'b0));
        drive(4'b0010, 64'd3, 64'd3);
        tick();
        check_out("bp.hold1", 64'd2, 1'b0, 1'b0);
        check("bp.stall_ready", N'(in_ready), N'(1'b0));
        tick();
        check_out("bp.hold2", 64'd2, 1'b0, 1'b0);
        out_ready = 1'b1;
        #1;
        check("bp.release_ready", N'(in_ready), N'(1'b1));
        tick();
        check_out("bp.second", 64'd4, 1'b0, 1'b0);
        idle();
        tick();
        check_out("bp.third", 64'd6, 1'b0, 1'b0);
        tick();
        check("bp.drain", N'(out_valid), N'(1'b0));

        // 6. reset with two tokens in flight
        out_ready = 1'b0;
        drive(4'b0010, 64'd7, 64'd7);
        tick();
        drive(4'b0010, 64'd8, 64'd8);
        tick();
        check_out("rst2.inflight", 64'd14, 1'b0, 1'b0);
        idle();
        reset = 1'b0;
        tick();
        check("rst2.out_valid", N'(out_valid), N'(1'b0));
        check("rst2.result", result, '0);
        check("rst2.in_ready", N'(in_ready), N'(1'b1));
        reset     = 1'b1;
        out_ready = 1'b1;
        tick();
        check("rst2.no_stale", N'(out_valid), N'(1'b0));
        drive(4'b0010, 64'd1, 64'd2);
        tick();
        idle();
        tick();
        check_out("rst2.add", 64'd3, 1'b0, 1'b0);
        tick();
        check("rst2.drain", N'(out_valid), N'(1'b0));

        // final report
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
